inorder_rs_entry_array: RTL

- Storage side of an in-order reservation station: the entry array whose status the allocate/issue pointer unit reads.
- Accepts 1–2 dispatched instructions per cycle at the allocation pointer.
- Captures source operands from two result broadcast buses (CDB).
- Exports busy, next-busy and ready vectors, and provides the entry selected by the issue pointer.

---
 rtl/inorder_rs_entry_array_pkg.sv | 31 +++
 rtl/inorder_rs_entry_array_src_operand.sv | 84 ++++++++
 rtl/inorder_rs_entry_array.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/inorder_rs_entry_array_pkg.sv
// Shared definitions for the in-order reservation station entry array.
// Holds the default geometry, the operand and entry record types and the
// CDB tag-compare helper used by every operand slot.
package inorder_rs_entry_array_pkg;

  localparam int unsigned ENT_SEL     = 2;
  localparam int unsigned ENT_NUM     = 4;   // must equal 2**ENT_SEL
  localparam int unsigned DATA_LEN    = 32;
  localparam int unsigned RRF_SEL     = 6;
  localparam int unsigned PAYLOAD_LEN = 64;

  // A not-yet-valid source keeps its rename tag in value[RRF_SEL-1:0].
  typedef struct packed {
    logic [DATA_LEN-1:0] value;
    logic                valid;
  } rs_src_t;

  typedef struct packed {
    logic                   busy;
    logic [PAYLOAD_LEN-1:0] payload;
    rs_src_t                src1;
    rs_src_t                src2;
  } rs_entry_t;

  function automatic logic tag_match(input logic [RRF_SEL-1:0] src_tag,
                                     input logic               cdb_en,
                                     input logic [RRF_SEL-1:0] cdb_tag);
    return cdb_en && (src_tag == cdb_tag);
  endfunction

endpackage

// File: rtl/inorder_rs_entry_array_src_operand.sv
// One source-operand slot of a reservation station entry.
// Loads on dispatch (capturing a same-cycle CDB hit so the wakeup is not
// lost), otherwise wakes up from either CDB while the entry is live; cdb1
// wins when both buses carry the awaited tag. A valid source never changes
// except by a new write.
// Config macro: RS_ISSUE_BYPASS_EN -- when defined, src_o also reflects a
// same-cycle CDB hit so the entry can issue in the broadcast cycle.
// Ports:
//   clk_i, reset_i           clock, synchronous active-high reset
//   wr_en_i/wr_value_i/wr_valid_i  dispatch write of this slot
//   wake_en_i                entry busy and not being flushed
//   cdb{1,2}_{en,tag,data}_i result broadcast buses
//   src_o                    read view of the operand (value, valid)
module rs_src_operand
  import inorder_rs_entry_array_pkg::*;
(
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                wr_en_i,
  input  logic [DATA_LEN-1:0] wr_value_i,
  input  logic                wr_valid_i,
  input  logic                wake_en_i,
  input  logic                cdb1_en_i,
  input  logic [RRF_SEL-1:0]  cdb1_tag_i,
  input  logic [DATA_LEN-1:0] cdb1_data_i,
  input  logic                cdb2_en_i,
  input  logic [RRF_SEL-1:0]  cdb2_tag_i,
  input  logic [DATA_LEN-1:0] cdb2_data_i,
  output rs_src_t             src_o
);

  rs_src_t r_src;
  rs_src_t w_src_d;
  rs_src_t w_load;
  logic    w_wr_m1, w_wr_m2, w_st_m1, w_st_m2;

  always_comb begin
    w_wr_m1 = ~wr_valid_i & tag_match(wr_value_i[RRF_SEL-1:0], cdb1_en_i, cdb1_tag_i);
    w_wr_m2 = ~wr_valid_i & tag_match(wr_value_i[RRF_SEL-1:0], cdb2_en_i, cdb2_tag_i);
    w_st_m1 = wake_en_i & ~r_src.valid & tag_match(r_src.value[RRF_SEL-1:0], cdb1_en_i,
                                                   cdb1_tag_i);
    w_st_m2 = wake_en_i & ~r_src.valid & tag_match(r_src.value[RRF_SEL-1:0], cdb2_en_i,
                                                   cdb2_tag_i);

    w_load.value = wr_value_i;
    w_load.valid = wr_valid_i;
    if (w_wr_m1) begin
      w_load = '{value: cdb1_data_i, valid: 1'b1};
    end else if (w_wr_m2) begin
      w_load = '{value: cdb2_data_i, valid: 1'b1};
    end

    w_src_d = r_src;
    if (wr_en_i) begin
      w_src_d = w_load;
    end else if (w_st_m1) begin
      w_src_d = '{value: cdb1_data_i, valid: 1'b1};
    end else if (w_st_m2) begin
      w_src_d = '{value: cdb2_data_i, valid: 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_src <= '0;
    end else begin
      r_src <= w_src_d;
    end
  end

`ifdef RS_ISSUE_BYPASS_EN
  always_comb begin
    src_o = r_src;
    if (w_st_m1) begin
      src_o = '{value: cdb1_data_i, valid: 1'b1};
    end else if (w_st_m2) begin
      src_o = '{value: cdb2_data_i, valid: 1'b1};
    end
  end
`else
  assign src_o = r_src;
`endif

endmodule

// File: rtl/inorder_rs_entry_array.sv
// Entry array of an in-order reservation station.
// Accepts up to two dispatches per cycle at alloc_ptr_i and alloc_ptr_i+1
// (wrapping), wakes sources from two CDBs, exports busy / next-busy / ready
// vectors and presents the entry at issue_ptr_i for issue.
// Config macro: RS_ISSUE_BYPASS_EN -- when defined, ready and issue operands
// include same-cycle CDB hits (handled inside each operand slot).
// Ports:
//   clk_i, reset_i                 clock, synchronous active-high reset
//   alloc_ptr_i, wr_en_{1,2}_i     dispatch base index and slot enables
//   wr_payload_*, wr_src*_*, wr_src*_vld_*  dispatched entry contents
//   cdb{1,2}_{en,tag,data}_i       result broadcast buses
//   issue_en_i, issue_ptr_i        consume / read entry
//   kill_i                         flush all entries
//   busy_vector_o, busy_vector_next_o, ready_vector_o  status vectors
//   iss_payload_o, iss_src{1,2}_o  contents of entry issue_ptr_i
module inorder_rs_entry_array
  import inorder_rs_entry_array_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [ENT_SEL-1:0]     alloc_ptr_i,
  input  logic                   wr_en_1_i,
  input  logic                   wr_en_2_i,
  input  logic [PAYLOAD_LEN-1:0] wr_payload_1_i,
  input  logic [PAYLOAD_LEN-1:0] wr_payload_2_i,
  input  logic [DATA_LEN-1:0]    wr_src1_1_i,
  input  logic [DATA_LEN-1:0]    wr_src2_1_i,
  input  logic [DATA_LEN-1:0]    wr_src1_2_i,
  input  logic [DATA_LEN-1:0]    wr_src2_2_i,
  input  logic                   wr_src1_vld_1_i,
  input  logic                   wr_src2_vld_1_i,
  input  logic                   wr_src1_vld_2_i,
  input  logic                   wr_src2_vld_2_i,
  input  logic                   cdb1_en_i,
  input  logic                   cdb2_en_i,
  input  logic [RRF_SEL-1:0]     cdb1_tag_i,
  input  logic [RRF_SEL-1:0]     cdb2_tag_i,
  input  logic [DATA_LEN-1:0]    cdb1_data_i,
  input  logic [DATA_LEN-1:0]    cdb2_data_i,
  input  logic                   issue_en_i,
  input  logic [ENT_SEL-1:0]     issue_ptr_i,
  input  logic                   kill_i,
  output logic [ENT_NUM-1:0]     busy_vector_o,
  output logic [ENT_NUM-1:0]     busy_vector_next_o,
  output logic [ENT_NUM-1:0]     ready_vector_o,
  output logic [PAYLOAD_LEN-1:0] iss_payload_o,
  output logic [DATA_LEN-1:0]    iss_src1_o,
  output logic [DATA_LEN-1:0]    iss_src2_o
);

  logic [ENT_NUM-1:0]     r_busy;
  logic [ENT_NUM-1:0]     w_busy_d;
  logic [ENT_NUM-1:0]     w_sel1, w_sel2, w_set, w_clr;
  logic [ENT_SEL-1:0]     w_idx2;
  logic [PAYLOAD_LEN-1:0] r_payload [ENT_NUM];
  rs_entry_t              w_entry   [ENT_NUM];

  // Natural ENT_SEL-bit overflow gives the wrap to entry 0.
  assign w_idx2 = alloc_ptr_i + ENT_SEL'(1);

  always_comb begin
    w_sel1 = '0;
    w_sel2 = '0;
    w_clr  = '0;
    for (int e = 0; e < ENT_NUM; e++) begin
      w_sel1[e] = ~kill_i & wr_en_1_i & (alloc_ptr_i == ENT_SEL'(e));
      w_sel2[e] = ~kill_i & wr_en_2_i & (w_idx2 == ENT_SEL'(e));
      w_clr[e]  = issue_en_i & (issue_ptr_i == ENT_SEL'(e));
    end
    w_set = w_sel1 | w_sel2;
    // Set after clear: a write to the issued index keeps the entry busy.
    w_busy_d = kill_i ? '0 : ((r_busy & ~w_clr) | w_set);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_busy <= '0;
      for (int e = 0; e < ENT_NUM; e++) begin
        r_payload[e] <= '0;
      end
    end else begin
      r_busy <= w_busy_d;
      for (int e = 0; e < ENT_NUM; e++) begin
        if (w_sel2[e]) begin
          r_payload[e] <= wr_payload_2_i;
        end else if (w_sel1[e]) begin
          r_payload[e] <= wr_payload_1_i;
        end
      end
    end
  end

  for (genvar g = 0; g < ENT_NUM; g++) begin : g_ent
    logic [DATA_LEN-1:0] w_s1_val, w_s2_val;
    logic                w_s1_vld, w_s2_vld, w_wake;
    rs_src_t             w_src1, w_src2;

    assign w_s1_val = w_sel2[g] ? wr_src1_2_i     : wr_src1_1_i;
    assign w_s2_val = w_sel2[g] ? wr_src2_2_i     : wr_src2_1_i;
    assign w_s1_vld = w_sel2[g] ? wr_src1_vld_2_i : wr_src1_vld_1_i;
    assign w_s2_vld = w_sel2[g] ? wr_src2_vld_2_i : wr_src2_vld_1_i;
    assign w_wake   = r_busy[g] & ~kill_i;

    rs_src_operand u_src1 (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .wr_en_i     (w_set[g]),
      .wr_value_i  (w_s1_val),
      .wr_valid_i  (w_s1_vld),
      .wake_en_i   (w_wake),
      .cdb1_en_i   (cdb1_en_i),
      .cdb1_tag_i  (cdb1_tag_i),
      .cdb1_data_i (cdb1_data_i),
      .cdb2_en_i   (cdb2_en_i),
      .cdb2_tag_i  (cdb2_tag_i),
      .cdb2_data_i (cdb2_data_i),
      .src_o       (w_src1)
    );

    rs_src_operand u_src2 (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .wr_en_i     (w_set[g]),
      .wr_value_i  (w_s2_val),
      .wr_valid_i  (w_s2_vld),
      .wake_en_i   (w_wake),
      .cdb1_en_i   (cdb1_en_i),
      .cdb1_tag_i  (cdb1_tag_i),
      .cdb1_data_i (cdb1_data_i),
      .cdb2_en_i   (cdb2_en_i),
      .cdb2_tag_i  (cdb2_tag_i),
      .cdb2_data_i (cdb2_data_i),
      .src_o       (w_src2)
    );

    assign w_entry[g] = '{busy: r_busy[g], payload: r_payload[g], src1: w_src1, src2: w_src2};
    assign ready_vector_o[g] = w_entry[g].busy & w_entry[g].src1.valid & w_entry[g].src2.valid;
  end

  assign busy_vector_o      = r_busy;
  assign busy_vector_next_o = w_busy_d;
  assign iss_payload_o      = w_entry[issue_ptr_i].payload;
  assign iss_src1_o         = w_entry[issue_ptr_i].src1.value;
  assign iss_src2_o         = w_entry[issue_ptr_i].src2.value;

endmodule
